// File: rtl/rp8_bd_mem_pkg.sv
// rp8_bd_pkg: shared definitions for the rp8 data-bus memory responder.
//   BD_DAW / BD_DW / BD_IDW : default address, data and tag widths
//   bd_state_e              : acknowledge FSM states
//   rsp_t                   : one read-response pipeline entry
package rp8_bd_pkg;

    localparam int BD_DAW = 13;
    localparam int BD_DW  = 8;
    localparam int BD_IDW = 6;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bd_state_e;

    typedef struct packed {
        logic              vld;
        logic [BD_IDW-1:0] id;
        logic [BD_DW-1:0]  dat;
        logic              per;
    } rsp_t;

endpackage

// File: rtl/rp8_bd_mem_if.sv
// rp8_bd_mem_if: bd_* request/response bus between the rp8 core and its data memory.
//   master : core side (drives request fields and per_inj, receives ack/response)
//   slave  : memory side (receives request fields, drives ack/response)
interface rp8_bd_mem_if
    import rp8_bd_pkg::*;
#(
    parameter int DAW = BD_DAW,
    parameter int DW  = BD_DW,
    parameter int IDW = BD_IDW
) ();

    logic           bd_req;
    logic           bd_wen;
    logic [DAW-1:0] bd_adr;
    logic [IDW-1:0] bd_wid;
    logic [DW-1:0]  bd_wdt;
    logic           per_inj;
    logic           bd_ack;
    logic           bd_ren;
    logic [IDW-1:0] bd_rid;
    logic [DW-1:0]  bd_rdt;
    logic           bd_per;

    modport master (
        output bd_req, bd_wen, bd_adr, bd_wid, bd_wdt, per_inj,
        input  bd_ack, bd_ren, bd_rid, bd_rdt, bd_per
    );

    modport slave (
        input  bd_req, bd_wen, bd_adr, bd_wid, bd_wdt, per_inj,
        output bd_ack, bd_ren, bd_rid, bd_rdt, bd_per
    );

endinterface

// File: rtl/rp8_bd_mem_rsp_pipe.sv
// rp8_bd_rsp_pipe: LAT-stage delay line for read responses.
//   clk : clock
//   rst : async active-low clear of the valid bits only
//   d   : response entering in the ack cycle
//   q   : response LAT cycles later
module rp8_bd_rsp_pipe
    import rp8_bd_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  rsp_t d,
    output rsp_t q
);

    logic vld_q [LAT];
    rsp_t pay_q [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) vld_q[i] <= 1'b0;
        end else begin
            vld_q[0] <= d.vld;
            for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // Payload needs no reset; it is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        pay_q[0] <= d;
        for (int i = 1; i < LAT; i++) pay_q[i] <= pay_q[i-1];
    end

    always_comb begin
        q     = pay_q[LAT-1];
        q.vld = vld_q[LAT-1];
    end

endmodule

// File: rtl/rp8_bd_mem.sv
// rp8_bd_mem: memory-side responder for the rp8 bd_* data bus.
// Accepts a request after WS wait states, writes into a 2**DAW byte array,
// and returns tagged read data LAT cycles after the ack cycle.
//   clk : clock
//   rst : async active-low reset
//   bd  : rp8_bd_mem_if.slave (request in, ack and read response out)
// Optional build macro RP8_BD_MEM_PARITY_EN: stores a parity bit per byte
// (inverted by per_inj on write) and flags mismatches on bd_per.
//
// state | meaning
// IDLE  | no request in progress; with WS=0 acks bd_req directly
// WAIT  | counting down wait states for the held request
module rp8_bd_mem
    import rp8_bd_pkg::*;
#(
    parameter int DAW = BD_DAW,
    parameter int DW  = BD_DW,
    parameter int IDW = BD_IDW,
    parameter int WS  = 0,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    rp8_bd_mem_if.slave  bd
);

`ifdef RP8_BD_MEM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif
    localparam logic [2:0] CNT_LOAD = (WS > 0) ? 3'(WS - 1) : 3'd0;

    bd_state_e      state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           ack_c;
    logic           acc;
    logic [MW-1:0]  mem [2**DAW];
    logic [MW-1:0]  wr_word;
    logic [MW-1:0]  rd_word;
    logic           rd_per;
    rsp_t           rsp_d, rsp_q;
    logic [IDW-1:0] rid_q;
    logic [DW-1:0]  rdt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bd.bd_req) begin
                    if (WS == 0) begin
                        ack_c = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bd.bd_req) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    ack_c   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With WS=0 the ack is combinational from bd_req, so it must be masked
    // explicitly while reset is held.
    assign acc       = ack_c & rst;
    assign bd.bd_ack = acc;

`ifdef RP8_BD_MEM_PARITY_EN
    assign wr_word = {(^bd.bd_wdt) ^ bd.per_inj, bd.bd_wdt};
    assign rd_per  = rd_word[DW] ^ (^rd_word[DW-1:0]);
`else
    logic unused_per_inj;
    assign unused_per_inj = bd.per_inj;
    assign wr_word        = bd.bd_wdt;
    assign rd_per         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (acc && bd.bd_wen) mem[bd.bd_adr] <= wr_word;
    end

    // Asynchronous read: a write at the previous edge is already visible.
    assign rd_word = mem[bd.bd_adr];

    always_comb begin
        rsp_d     = '0;
        rsp_d.vld = acc & ~bd.bd_wen;
        rsp_d.id  = bd.bd_wid;
        rsp_d.dat = rd_word[DW-1:0];
        rsp_d.per = rd_per;
    end

    rp8_bd_rsp_pipe #(.LAT(LAT)) u_rsp_pipe (
        .clk (clk),
        .rst (rst),
        .d   (rsp_d),
        .q   (rsp_q)
    );

    // Tag/data hold their last response between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rid_q <= '0;
            rdt_q <= '0;
        end else if (rsp_q.vld) begin
            rid_q <= rsp_q.id;
            rdt_q <= rsp_q.dat;
        end
    end

    assign bd.bd_ren = rsp_q.vld;
    assign bd.bd_rid = rsp_q.vld ? rsp_q.id  : rid_q;
    assign bd.bd_rdt = rsp_q.vld ? rsp_q.dat : rdt_q;
    assign bd.bd_per = rsp_q.vld & rsp_q.per;

endmodule

// File: tb/tb_rp8_bd_mem.sv
// Bench for rp8_bd_mem: three instances (WS0/LAT1, WS3/LAT2, WS0/LAT4).
// Instances 0 and 2 share one stimulus stream; instance 1 has its own.
module tb_rp8_bd_mem;

    localparam int WSV  [2] = '{0, 3};
    localparam int LATV [3] = '{1, 2, 4};
    localparam int GRP  [3] = '{0, 1, 0};
`ifdef RP8_BD_MEM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    typedef struct {
        int         due;
        logic [5:0] id;
        logic [7:0] dt;
        logic       per;
    } exp_t;

    typedef struct {
        logic        req;
        logic        wen;
        logic [12:0] adr;
        logic [5:0]  wid;
        logic [7:0]  wdt;
        logic        ack;
        logic        ren;
        logic [5:0]  rid;
        logic [7:0]  rdt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_g   [2];
    logic        drv_req [2];
    logic        drv_wen [2];
    logic        drv_inj [2];
    logic [12:0] drv_adr [2];
    logic [5:0]  drv_wid [2];
    logic [7:0]  drv_wdt [2];

    logic        a_ack [3];
    logic        a_ren [3];
    logic        a_per [3];
    logic [5:0]  a_rid [3];
    logic [7:0]  a_rdt [3];

    rp8_bd_mem_if bus [3] ();

    for (genvar k = 0; k < 3; k++) begin : g_dut
        assign bus[k].bd_req  = drv_req[GRP[k]];
        assign bus[k].bd_wen  = drv_wen[GRP[k]];
        assign bus[k].bd_adr  = drv_adr[GRP[k]];
        assign bus[k].bd_wid  = drv_wid[GRP[k]];
        assign bus[k].bd_wdt  = drv_wdt[GRP[k]];
        assign bus[k].per_inj = drv_inj[GRP[k]];
        assign a_ack[k] = bus[k].bd_ack;
        assign a_ren[k] = bus[k].bd_ren;
        assign a_per[k] = bus[k].bd_per;
        assign a_rid[k] = bus[k].bd_rid;
        assign a_rdt[k] = bus[k].bd_rdt;

        rp8_bd_mem #(.WS(WSV[GRP[k]]), .LAT(LATV[k])) u_dut (
            .clk (clk),
            .rst (rst_g[GRP[k]]),
            .bd  (bus[k])
        );
    end

    // Reference state
    logic [7:0]  mm [2][8192];
    logic        mp [2][8192];
    exp_t        q  [3][$];
    int          run [2];
    logic        ack_m [2];
    logic [5:0]  last_rid [3];
    logic [7:0]  last_rdt [3];
    int          cyc;
    int          n_chk;
    int          n_err;

    logic        s_ack [3];
    logic        s_ren [3];
    logic        s_per [3];
    logic [5:0]  s_rid [3];
    logic [7:0]  s_rdt [3];

    logic [12:0] pool [8] = '{13'h0100, 13'h0010, 13'h1FFF, 13'h0000,
                              13'h0ABC, 13'h1234, 13'h0777, 13'h1555};
    vec_t        tv [8];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    // One bus cycle: sample after inputs settle, compare with the model,
    // then commit the model's view of the closing clock edge.
    task automatic tick();
        exp_t e;
        logic er, ep;
        #1;
        for (int g = 0; g < 2; g++) begin
            ack_m[g] = 1'b0;
            if (!rst_g[g] || !drv_req[g]) begin
                run[g] = 0;
            end else begin
                run[g]++;
                if (run[g] == WSV[g] + 1) begin
                    ack_m[g] = 1'b1;
                    run[g]   = 0;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            automatic int g = GRP[k];
            if (!rst_g[g]) begin
                q[k].delete();
                last_rid[k] = '0;
                last_rdt[k] = '0;
            end
            er = 1'b0;
            ep = 1'b0;
            if (q[k].size() != 0 && q[k][0].due == cyc) begin
                e = q[k].pop_front();
                er = 1'b1;
                ep = e.per;
                last_rid[k] = e.id;
                last_rdt[k] = e.dt;
            end
            chk("ack", k, 32'(a_ack[k]), 32'(ack_m[g]));
            chk("ren", k, 32'(a_ren[k]), 32'(er));
            chk("rid", k, 32'(a_rid[k]), 32'(last_rid[k]));
            chk("rdt", k, 32'(a_rdt[k]), 32'(last_rdt[k]));
            chk("per", k, 32'(a_per[k]), 32'(ep));
            s_ack[k] = a_ack[k];
            s_ren[k] = a_ren[k];
            s_per[k] = a_per[k];
            s_rid[k] = a_rid[k];
            s_rdt[k] = a_rdt[k];
            if (ack_m[g] && !drv_wen[g])
                q[k].push_back('{due: cyc + LATV[k], id: drv_wid[g],
                                 dt: mm[g][drv_adr[g]], per: PAR & mp[g][drv_adr[g]]});
        end
        for (int g = 0; g < 2; g++) begin
            if (ack_m[g] && drv_wen[g]) begin
                mm[g][drv_adr[g]] = drv_wdt[g];
                mp[g][drv_adr[g]] = drv_inj[g];
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic access(input int g, input logic wen, input logic [12:0] adr,
                          input logic [5:0] wid, input logic [7:0] wdt, input logic inj);
        drv_req[g] = 1'b1;
        drv_wen[g] = wen;
        drv_adr[g] = adr;
        drv_wid[g] = wid;
        drv_wdt[g] = wdt;
        drv_inj[g] = inj;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack_m[g]) break;
        end
        drv_req[g] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        for (int g = 0; g < 2; g++) begin
            rst_g[g] = 1'b1; drv_req[g] = 1'b0; drv_wen[g] = 1'b0; drv_inj[g] = 1'b0;
            drv_adr[g] = '0; drv_wid[g] = '0; drv_wdt[g] = '0; run[g] = 0; ack_m[g] = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            last_rid[k] = '0;
            last_rdt[k] = '0;
        end
        //            req   wen   adr       wid    wdt     ack   ren   rid    rdt
        tv[0] = '{1'b1, 1'b1, 13'h0100, 6'h00, 8'h5A, 1'b1, 1'b0, 6'h00, 8'h00};
        tv[1] = '{1'b1, 1'b0, 13'h0100, 6'h2A, 8'h00, 1'b1, 1'b0, 6'h00, 8'h00};
        tv[2] = '{1'b0, 1'b0, 13'h0000, 6'h00, 8'h00, 1'b0, 1'b1, 6'h2A, 8'h5A};
        tv[3] = '{1'b1, 1'b1, 13'h0200, 6'h00, 8'h33, 1'b1, 1'b0, 6'h2A, 8'h5A};
        tv[4] = '{1'b1, 1'b0, 13'h0200, 6'h05, 8'h00, 1'b1, 1'b0, 6'h2A, 8'h5A};
        tv[5] = '{1'b1, 1'b0, 13'h0100, 6'h06, 8'h00, 1'b1, 1'b1, 6'h05, 8'h33};
        tv[6] = '{1'b0, 1'b0, 13'h0000, 6'h00, 8'h00, 1'b0, 1'b1, 6'h06, 8'h5A};
        tv[7] = '{1'b0, 1'b0, 13'h0000, 6'h00, 8'h00, 1'b0, 1'b0, 6'h06, 8'h5A};

        @(negedge clk);
        rst_g[0] = 1'b0;
        rst_g[1] = 1'b0;
        drv_req[0] = 1'b1;
        drv_req[1] = 1'b1;
        tick();
        tick();
        drv_req[0] = 1'b0;
        drv_req[1] = 1'b0;
        rst_g[0] = 1'b1;
        rst_g[1] = 1'b1;
        tick();

        // WS=0/LAT=1 vectors: write, read-after-write, back-to-back reads, hold
        for (int i = 0; i < 8; i++) begin
            drv_req[0] = tv[i].req;
            drv_wen[0] = tv[i].wen;
            drv_adr[0] = tv[i].adr;
            drv_wid[0] = tv[i].wid;
            drv_wdt[0] = tv[i].wdt;
            drv_inj[0] = 1'b0;
            tick();
            chk("tv_ack", i, 32'(s_ack[0]), 32'(tv[i].ack));
            chk("tv_ren", i, 32'(s_ren[0]), 32'(tv[i].ren));
            chk("tv_rid", i, 32'(s_rid[0]), 32'(tv[i].rid));
            chk("tv_rdt", i, 32'(s_rdt[0]), 32'(tv[i].rdt));
        end

        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 8; i++)
                access(g, 1'b1, pool[i], 6'h00, 8'($urandom), 1'b0);
        access(1, 1'b1, 13'h1FFF, 6'h00, 8'hC3, 1'b0);
        access(1, 1'b1, 13'h0010, 6'h00, 8'h77, 1'b0);
        tick();

        // WS=3: ack only in 4th request cycle, data two cycles later
        drv_req[1] = 1'b1; drv_wen[1] = 1'b0; drv_adr[1] = 13'h1FFF; drv_wid[1] = 6'h15;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ws3_ack", i, 32'(s_ack[1]), 32'(i == 3));
        end
        drv_req[1] = 1'b0;
        tick();
        chk("ws3_early", 0, 32'(s_ren[1]), 32'd0);
        tick();
        chk("ws3_ren", 0, 32'(s_ren[1]), 32'd1);
        chk("ws3_rdt", 0, 32'(s_rdt[1]), 32'hC3);
        chk("ws3_rid", 0, 32'(s_rid[1]), 32'h15);

        // WS=3: aborted write leaves old contents
        drv_req[1] = 1'b1; drv_wen[1] = 1'b1; drv_adr[1] = 13'h0010; drv_wdt[1] = 8'hFF;
        tick();
        chk("abort_ack", 0, 32'(s_ack[1]), 32'd0);
        drv_req[1] = 1'b0;
        tick();
        chk("abort_ack", 1, 32'(s_ack[1]), 32'd0);
        access(1, 1'b0, 13'h0010, 6'h09, 8'h00, 1'b0);
        tick();
        tick();
        chk("abort_ren", 0, 32'(s_ren[1]), 32'd1);
        chk("abort_rdt", 0, 32'(s_rdt[1]), 32'h77);

        // WS=0/LAT=4: four back-to-back reads, responses in tag order
        for (int j = 0; j < 4; j++) begin
            drv_req[0] = 1'b1; drv_wen[0] = 1'b0; drv_adr[0] = pool[j]; drv_wid[0] = 6'(j + 1);
            tick();
            chk("b2b_ack", j, 32'(s_ack[0]), 32'd1);
        end
        drv_req[0] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("b2b_ren", j, 32'(s_ren[2]), 32'(j < 4));
            if (j < 4) chk("b2b_rid", j, 32'(s_rid[2]), 32'(j + 1));
        end

        // Reset one cycle after a read ack drops the in-flight response
        access(0, 1'b0, pool[3], 6'h3F, 8'h00, 1'b0);
        rst_g[0] = 1'b0;
        tick();
        rst_g[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("rst_ren", j, 32'(s_ren[2]), 32'd0);
            chk("rst_rid", j, 32'(s_rid[2]), 32'd0);
            chk("rst_rdt", j, 32'(s_rdt[2]), 32'd0);
        end

        // Parity injection and clean parity
        access(0, 1'b1, pool[4], 6'h00, 8'h01, 1'b1);
        access(0, 1'b0, pool[4], 6'h21, 8'h00, 1'b0);
        tick();
        chk("par_ren", 0, 32'(s_ren[0]), 32'd1);
        chk("par_rdt", 0, 32'(s_rdt[0]), 32'h01);
        chk("par_per", 0, 32'(s_per[0]), 32'(PAR));
        access(0, 1'b1, pool[4], 6'h00, 8'h01, 1'b0);
        access(0, 1'b0, pool[4], 6'h22, 8'h00, 1'b0);
        tick();
        chk("par_ren", 1, 32'(s_ren[0]), 32'd1);
        chk("par_per", 1, 32'(s_per[0]), 32'd0);

        // Random traffic on both streams, with held requests and aborts
        for (int n = 0; n < 600; n++) begin
            for (int g = 0; g < 2; g++) begin
                if (drv_req[g] && !ack_m[g]) begin
                    if ($urandom_range(15) == 0) drv_req[g] = 1'b0;
                end else begin
                    drv_req[g] = ($urandom_range(3) != 0);
                    drv_wen[g] = 1'($urandom_range(1));
                    drv_adr[g] = pool[$urandom_range(7)];
                    drv_wid[g] = 6'($urandom);
                    drv_wdt[g] = 8'($urandom);
                    drv_inj[g] = ($urandom_range(7) == 0);
                end
            end
            tick();
        end
        drv_req[0] = 1'b0;
        drv_req[1] = 1'b0;
        for (int j = 0; j < 6; j++) tick();
        for (int k = 0; k < 3; k++) chk("drain", k, 32'(q[k].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
